// File: rtl/mem_port_sched.sv
// Single memory port scheduler: fetch/load arbitration with fetch anti-starvation,
// an in-order store buffer with youngest-match load forwarding, and a flush sequence.
module mem_port_sched #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned SB_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        f_req,
    input  logic [AW-1:0]               f_addr,
    output logic                        f_gnt,
    output logic                        f_rvalid,
    output logic [DW-1:0]               f_rdata,
    input  logic                        l_req,
    input  logic [AW-1:0]               l_addr,
    output logic                        l_gnt,
    output logic                        l_rvalid,
    output logic [DW-1:0]               l_rdata,
    input  logic                        s_req,
    input  logic [AW-1:0]               s_addr,
    input  logic [DW-1:0]               s_data,
    output logic                        s_ack,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_rdata,
    output logic [$clog2(SB_DEPTH):0]   sb_count
);

    localparam int unsigned PW  = $clog2(SB_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned STW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [STW-1:0]  starve_q;
    logic [AW-1:0]   sb_addr_q [SB_DEPTH];
    logic [DW-1:0]   sb_data_q [SB_DEPTH];

    logic            f_rvalid_q, l_rvalid_q, l_fwd_q;
    logic [DW-1:0]   l_fwd_data_q;

    logic            live, full, not_empty;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
    logic            drain, l_rd, l_fwd_gnt;

    // Outputs are forced quiet while reset is held, independent of the request inputs.
    assign live      = !rst;
    assign full      = (count_q == CW'(SB_DEPTH));
    assign not_empty = (count_q != '0);
    assign s_ack     = live && (state_q == StRun) && s_req && !full;

    // Scan oldest to youngest so the last match wins; a same-cycle store is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CW'(i) < count_q) && (sb_addr_q[head_q + PW'(i)] == l_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[head_q + PW'(i)];
            end
        end
        if (s_ack && (s_addr == l_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (flush_req) state_d = StFlush;
            end
            StFlush: begin
                if (!flush_req) begin
                    state_d = StRun;
                end else if (!not_empty || (count_q == CW'(1))) begin
                    // With one entry left it drains this cycle, so done follows the dequeue edge.
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!flush_req) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        f_gnt     = 1'b0;
        l_rd      = 1'b0;
        l_fwd_gnt = 1'b0;
        drain     = 1'b0;
        if (live) begin
            unique case (state_q)
                StRun: begin
                    l_fwd_gnt = l_req && fwd_hit;
                    if (full) begin
                        drain = 1'b1;
                    end else if (f_req && (starve_q == STW'(STARVE_MAX))) begin
                        f_gnt = 1'b1;
                    end else if (l_req && !fwd_hit) begin
                        l_rd = 1'b1;
                    end else if (f_req) begin
                        f_gnt = 1'b1;
                    end else if (not_empty) begin
                        drain = 1'b1;
                    end
                end
                StFlush: drain = not_empty;
                StDone:  drain = 1'b0;
                default: drain = 1'b0;
            endcase
        end
    end

    assign l_gnt = l_rd || l_fwd_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sb_addr_q[head_q];
            mem_wdata = sb_data_q[head_q];
        end else if (f_gnt) begin
            mem_en   = 1'b1;
            mem_addr = f_addr;
        end else if (l_rd) begin
            mem_en   = 1'b1;
            mem_addr = l_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
            end
        end else begin
            if (s_ack) begin
                sb_addr_q[tail_q] <= s_addr;
                sb_data_q[tail_q] <= s_data;
                tail_q            <= tail_q + PW'(1);
            end
            if (drain) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(s_ack) - CW'(drain);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (f_gnt || !f_req) begin
            starve_q <= '0;
        end else if (starve_q != STW'(STARVE_MAX)) begin
            starve_q <= starve_q + STW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
            l_fwd_q      <= 1'b0;
            l_fwd_data_q <= '0;
        end else begin
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt;
            l_fwd_q    <= l_fwd_gnt;
            if (l_fwd_gnt) l_fwd_data_q <= fwd_data;
        end
    end

    assign f_rvalid   = f_rvalid_q;
    assign f_rdata    = f_rvalid_q ? mem_rdata : '0;
    assign l_rvalid   = l_rvalid_q;
    assign l_rdata    = l_rvalid_q ? (l_fwd_q ? l_fwd_data_q : mem_rdata) : '0;
    assign flush_done = live && (state_q == StDone);
    assign sb_count   = count_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: per-cycle vector table plus reset sequences,
// with a behavioural synchronous memory behind the port.
module tb_mem_port_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0, l_req = 1'b0, s_req = 1'b0, flush_req = 1'b0;
    logic [15:0] f_addr = '0, l_addr = '0, s_addr = '0, s_data = '0;
    logic        f_gnt, f_rvalid, l_gnt, l_rvalid, s_ack, flush_done;
    logic [15:0] f_rdata, l_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  sb_count;

    mem_port_sched #(.AW(16), .DW(16), .SB_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_ack(s_ack),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    // Memory preset to 0x1000+addr on the first edge.
    logic [15:0] mem [256];
    logic        mem_init = 1'b0;
    int          wr_count = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_init  <= 1'b1;
            mem_rdata <= '0;
        end else begin
            if (mem_en && mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_count           <= wr_count + 1;
            end
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        int fr, fa, lr, la, sr, sa, sd, fl;
        int fg, lg, sk, en, we, ad, wd, frv, frd, lrv, lrd, cnt, fd;
    } vec_t;

    vec_t vt[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int row, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
    endtask

    task automatic idle_inputs();
        f_req = 0; l_req = 0; s_req = 0; flush_req = 0;
        f_addr = '0; l_addr = '0; s_addr = '0; s_data = '0;
    endtask

    initial begin
        // fr fa lr la sr sa sd fl | fg lg sk en we ad wd | frv frd lrv lrd cnt fd
        vt.push_back('{1,'h00,0,0,0,0,0,0, 1,0,0,1,0,'h00,0, 0,0,0,0,0,0});
        vt.push_back('{1,'h01,0,0,0,0,0,0, 1,0,0,1,0,'h01,0, 1,'h1000,0,0,0,0});
        vt.push_back('{1,'h02,0,0,0,0,0,0, 1,0,0,1,0,'h02,0, 1,'h1001,0,0,0,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h1002,0,0,0,0});
        vt.push_back('{0,0,0,0,1,'h10,'hBEEF,0, 0,0,1,0,0,0,0, 0,0,0,0,0,0});
        vt.push_back('{0,0,1,'h10,0,0,0,0, 0,1,0,1,1,'h10,'hBEEF, 0,0,0,0,1,0});
        vt.push_back('{0,0,1,'h10,1,'h10,'h1234,0, 0,1,1,0,0,0,0, 0,0,1,'hBEEF,0,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,1,1,'h10,'h1234, 0,0,1,'h1234,1,0});
        // buffer fills while fetch and load are held
        vt.push_back('{1,'h20,1,'h40,1,'h10,'hA000,0, 0,1,1,1,0,'h40,0, 0,0,0,0,0,0});
        vt.push_back('{1,'h20,1,'h40,1,'h11,'hA001,0, 0,1,1,1,0,'h40,0, 0,0,1,'h1040,1,0});
        vt.push_back('{1,'h20,1,'h40,1,'h12,'hA002,0, 0,1,1,1,0,'h40,0, 0,0,1,'h1040,2,0});
        vt.push_back('{1,'h20,1,'h40,1,'h13,'hA003,0, 1,0,1,1,0,'h20,0, 0,0,1,'h1040,3,0});
        vt.push_back('{1,'h20,1,'h40,1,'h14,'hA004,0, 0,0,0,1,1,'h10,'hA000, 1,'h1020,0,0,4,0});
        vt.push_back('{1,'h20,1,'h40,1,'h14,'hA004,0, 0,1,1,1,0,'h40,0, 0,0,0,0,3,0});
        vt.push_back('{1,'h20,1,'h40,0,0,0,0, 0,0,0,1,1,'h11,'hA001, 0,0,1,'h1040,4,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,1,1,'h12,'hA002, 0,0,0,0,3,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,1,1,'h13,'hA003, 0,0,0,0,2,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,1,1,'h14,'hA004, 0,0,0,0,1,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0});
        // starvation: loads win three times, then fetch
        vt.push_back('{1,'h30,1,'h50,0,0,0,0, 0,1,0,1,0,'h50,0, 0,0,0,0,0,0});
        vt.push_back('{1,'h30,1,'h51,0,0,0,0, 0,1,0,1,0,'h51,0, 0,0,1,'h1050,0,0});
        vt.push_back('{1,'h30,1,'h52,0,0,0,0, 0,1,0,1,0,'h52,0, 0,0,1,'h1051,0,0});
        vt.push_back('{1,'h30,1,'h53,0,0,0,0, 1,0,0,1,0,'h30,0, 0,0,1,'h1052,0,0});
        vt.push_back('{1,'h31,1,'h53,0,0,0,0, 0,1,0,1,0,'h53,0, 1,'h1030,0,0,0,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,1,'h1053,0,0});
        // flush
        vt.push_back('{1,'h70,0,0,1,'h60,'hE000,0, 1,0,1,1,0,'h70,0, 0,0,0,0,0,0});
        vt.push_back('{1,'h71,0,0,1,'h61,'hE001,0, 1,0,1,1,0,'h71,0, 1,'h1070,0,0,1,0});
        vt.push_back('{1,'h72,0,0,1,'h62,'hE002,0, 1,0,1,1,0,'h72,0, 1,'h1071,0,0,2,0});
        vt.push_back('{1,'h73,0,0,0,0,0,1, 1,0,0,1,0,'h73,0, 1,'h1072,0,0,3,0});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,1, 0,0,0,1,1,'h60,'hE000, 1,'h1073,0,0,3,0});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,1, 0,0,0,1,1,'h61,'hE001, 0,0,0,0,2,0});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,1, 0,0,0,1,1,'h62,'hE002, 0,0,0,0,1,0});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,1, 0,0,0,0,0,0,0, 0,0,0,0,0,1});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,0, 0,0,0,0,0,0,0, 0,0,0,0,0,1});
        vt.push_back('{1,'h74,1,'h75,1,'h63,'hE003,0, 1,0,1,1,0,'h74,0, 0,0,0,0,0,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,1,1,'h63,'hE003, 1,'h1074,0,0,1,0});
        vt.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0});

        // Reset held with requests active: everything must read 0.
        f_req = 1; f_addr = 16'h5; s_req = 1; s_addr = 16'h7;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_f_gnt", -1, int'(f_gnt), 0);
        chk("rst_s_ack", -1, int'(s_ack), 0);
        chk("rst_mem_en", -1, int'(mem_en), 0);
        chk("rst_sb_count", -1, int'(sb_count), 0);
        chk("rst_flush_done", -1, int'(flush_done), 0);
        idle_inputs();
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            f_req = vt[i].fr[0];  f_addr = 16'(vt[i].fa);
            l_req = vt[i].lr[0];  l_addr = 16'(vt[i].la);
            s_req = vt[i].sr[0];  s_addr = 16'(vt[i].sa); s_data = 16'(vt[i].sd);
            flush_req = vt[i].fl[0];
            #1;
            chk("f_gnt", i, int'(f_gnt), vt[i].fg);
            chk("l_gnt", i, int'(l_gnt), vt[i].lg);
            chk("s_ack", i, int'(s_ack), vt[i].sk);
            chk("mem_en", i, int'(mem_en), vt[i].en);
            chk("mem_we", i, int'(mem_we), vt[i].we);
            chk("mem_addr", i, int'(mem_addr), vt[i].ad);
            if (vt[i].we != 0) chk("mem_wdata", i, int'(mem_wdata), vt[i].wd);
            chk("f_rvalid", i, int'(f_rvalid), vt[i].frv);
            chk("f_rdata", i, int'(f_rdata), vt[i].frd);
            chk("l_rvalid", i, int'(l_rvalid), vt[i].lrv);
            chk("l_rdata", i, int'(l_rdata), vt[i].lrd);
            chk("sb_count", i, int'(sb_count), vt[i].cnt);
            chk("flush_done", i, int'(flush_done), vt[i].fd);
        end
        @(negedge clk);
        idle_inputs();
        chk("mem_10", -2, int'(mem[8'h10]), 'hA000);
        chk("mem_14", -2, int'(mem[8'h14]), 'hA004);
        chk("mem_62", -2, int'(mem[8'h62]), 'hE002);
        chk("mem_63", -2, int'(mem[8'h63]), 'hE003);

        // Async reset with two stores buffered and a fetch return pending.
        f_req = 1; f_addr = 16'h90; s_req = 1; s_addr = 16'h80; s_data = 16'hF000;
        @(negedge clk);
        f_addr = 16'h91; s_addr = 16'h81; s_data = 16'hF001;
        @(posedge clk);
        #2;
        chk("pre_rst_count", -3, int'(sb_count), 2);
        chk("pre_rst_frv", -3, int'(f_rvalid), 1);
        rst = 1;
        #1;
        chk("arst_f_rvalid", -3, int'(f_rvalid), 0);
        chk("arst_f_rdata", -3, int'(f_rdata), 0);
        chk("arst_sb_count", -3, int'(sb_count), 0);
        chk("arst_f_gnt", -3, int'(f_gnt), 0);
        chk("arst_mem_en", -3, int'(mem_en), 0);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        begin
            int wr0;
            wr0 = wr_count;
            repeat (6) @(negedge clk);
            #1;
            chk("post_rst_writes", -3, wr_count - wr0, 0);
            chk("post_rst_mem80", -3, int'(mem[8'h80]), 'h1080);
            chk("post_rst_mem_en", -3, int'(mem_en), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
